// File: rtl/tcam_lut_stage.sv
// -----------------------------------------------------------------------------
// tcam_lut_stage
//
// Lookup stage for the user data path, sitting between the input arbiter and
// the output queues. Each packet is buffered in a fallthrough data FIFO. The
// first data word (first word with ctrl == 0) supplies the lookup key, which
// is matched against a small ternary table. The result is queued as
// {hit, port}. When the packet leaves, the destination-port field of its IOQ
// module header is overwritten with the looked-up port.
//
// Optional build macro: TCAM_LUT_MISS_DROP_EN
//   defined   : packets whose lookup missed are silently drained.
//   undefined : missed packets are forwarded with DEFAULT_PORT.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   in_data/in_ctrl   : incoming packet word and control
//   in_wr / in_rdy    : input word valid / stage can take a word next cycle
//   out_data/out_ctrl : outgoing packet word and control
//   out_wr / out_rdy  : output word valid / downstream can accept
//   tbl_wr_*          : direct write port for one table entry
//                       (valid, value, care mask, one-hot port)
//   hit_count         : saturating count of lookups that matched
//   miss_count        : saturating count of lookups that missed
// -----------------------------------------------------------------------------
module tcam_lut_stage #(
  parameter int                    DATA_WIDTH      = 64,
  parameter int                    CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int                    KEY_WIDTH       = 48,
  parameter int                    NUM_ENTRIES     = 8,
  parameter int                    FIFO_DEPTH_BITS = 4,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL        = CTRL_WIDTH'(8'hFF),
  parameter logic [15:0]           DEFAULT_PORT    = 16'h0000,
  parameter int                    COUNT_WIDTH     = 32,
  localparam int                   AW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  input  logic                   in_wr,
  output logic                   in_rdy,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic                   out_wr,
  input  logic                   out_rdy,
  input  logic                   tbl_wr_en,
  input  logic [AW-1:0]          tbl_wr_addr,
  input  logic                   tbl_wr_valid,
  input  logic [KEY_WIDTH-1:0]   tbl_wr_value,
  input  logic [KEY_WIDTH-1:0]   tbl_wr_mask,
  input  logic [15:0]            tbl_wr_port,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);

  localparam int WW    = CTRL_WIDTH + DATA_WIDTH;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] D_FULL      = (FIFO_DEPTH_BITS+1)'(DEPTH);
  // One slot of slack so a word accepted while in_rdy was high still fits.
  localparam logic [FIFO_DEPTH_BITS:0] D_NEAR_FULL = (FIFO_DEPTH_BITS+1)'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0]   CNT_MAX     = '1;

`ifdef TCAM_LUT_MISS_DROP_EN
  localparam bit MISS_DROP = 1'b1;
`else
  localparam bit MISS_DROP = 1'b0;
`endif

  typedef enum logic {IN_HDR, IN_DATA} in_state_t;
  typedef enum logic [1:0] {OUT_WAIT, OUT_HDR, OUT_DATA} out_state_t;

  // ---------------------------------------------------------------- table
  logic                 valid_reg [NUM_ENTRIES];
  logic [KEY_WIDTH-1:0] value_reg [NUM_ENTRIES];
  logic [KEY_WIDTH-1:0] mask_reg  [NUM_ENTRIES];
  logic [15:0]          port_reg  [NUM_ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) valid_reg[i] <= 1'b0;
    end else if (tbl_wr_en) begin
      valid_reg[tbl_wr_addr] <= tbl_wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_wr_en) begin
      value_reg[tbl_wr_addr] <= tbl_wr_value;
      mask_reg[tbl_wr_addr]  <= tbl_wr_mask;
      port_reg[tbl_wr_addr]  <= tbl_wr_port;
    end
  end

  // --------------------------------------------------------------- lookup
  // The match reads the registered table, so a write in the same cycle as
  // the key word is only visible to later lookups.
  logic [KEY_WIDTH-1:0]   key;
  logic [NUM_ENTRIES-1:0] match;
  logic                   lk_hit;
  logic [15:0]            lk_port;

  assign key = in_data[DATA_WIDTH-1 -: KEY_WIDTH];

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] &&
                         (((key ^ value_reg[gi]) & mask_reg[gi]) == '0);
    end
  endgenerate

  // Scanning from the top down leaves the lowest matching index in place.
  always_comb begin
    lk_hit  = 1'b0;
    lk_port = DEFAULT_PORT;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        lk_hit  = 1'b1;
        lk_port = port_reg[i];
      end
    end
  end

  // ----------------------------------------------------------- data FIFO
  logic [WW-1:0]              dmem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] d_wr_ptr_reg, d_rd_ptr_reg;
  logic [FIFO_DEPTH_BITS:0]   d_count_reg;
  logic                       d_push, d_pop, d_empty, d_full, d_nearly_full;
  logic [WW-1:0]              d_head;

  assign d_empty       = (d_count_reg == '0);
  assign d_full        = (d_count_reg == D_FULL);
  assign d_nearly_full = (d_count_reg >= D_NEAR_FULL);
  assign d_push        = in_wr && !d_full;
  assign d_head        = dmem[d_rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (d_push) dmem[d_wr_ptr_reg] <= {in_ctrl, in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_wr_ptr_reg <= '0;
      d_rd_ptr_reg <= '0;
      d_count_reg  <= '0;
    end else begin
      if (d_push) d_wr_ptr_reg <= d_wr_ptr_reg + 1'b1;
      if (d_pop)  d_rd_ptr_reg <= d_rd_ptr_reg + 1'b1;
      case ({d_push, d_pop})
        2'b10:   d_count_reg <= d_count_reg + 1'b1;
        2'b01:   d_count_reg <= d_count_reg - 1'b1;
        default: d_count_reg <= d_count_reg;
      endcase
    end
  end

  // -------------------------------------------------------- input parser
  in_state_t in_state_reg;
  logic      key_word;
  logic      lk_pend_reg, lk_hit_reg;
  logic [15:0] lk_port_reg;

  assign key_word = d_push && (in_state_reg == IN_HDR) && (in_ctrl == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_reg <= IN_HDR;
      lk_pend_reg  <= 1'b0;
      lk_hit_reg   <= 1'b0;
      lk_port_reg  <= DEFAULT_PORT;
    end else begin
      lk_pend_reg <= key_word;
      if (key_word) begin
        lk_hit_reg  <= lk_hit;
        lk_port_reg <= lk_port;
      end
      case (in_state_reg)
        IN_HDR:  if (key_word) in_state_reg <= IN_DATA;
        IN_DATA: if (d_push && in_ctrl != '0) in_state_reg <= IN_HDR;
        default: in_state_reg <= IN_HDR;
      endcase
    end
  end

  // --------------------------------------------------------- result FIFO
  logic [16:0] rmem [4];
  logic [1:0]  r_wr_ptr_reg, r_rd_ptr_reg;
  logic [2:0]  r_count_reg;
  logic [2:0]  r_level;
  logic        r_push, r_pop, r_empty, r_nearly_full, r_hit;
  logic [15:0] r_port;

  assign r_push = lk_pend_reg;
  assign r_empty = (r_count_reg == 3'd0);
  // Count the lookup still in flight so in_rdy drops before space runs out.
  assign r_level = r_count_reg + {2'b00, lk_pend_reg};
  assign r_nearly_full = (r_level >= 3'd3);
  assign {r_hit, r_port} = rmem[r_rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (r_push) rmem[r_wr_ptr_reg] <= {lk_hit_reg, lk_port_reg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr_reg <= '0;
      r_rd_ptr_reg <= '0;
      r_count_reg  <= '0;
    end else begin
      if (r_push) r_wr_ptr_reg <= r_wr_ptr_reg + 1'b1;
      if (r_pop)  r_rd_ptr_reg <= r_rd_ptr_reg + 1'b1;
      case ({r_push, r_pop})
        2'b10:   r_count_reg <= r_count_reg + 1'b1;
        2'b01:   r_count_reg <= r_count_reg - 1'b1;
        default: r_count_reg <= r_count_reg;
      endcase
    end
  end

  assign in_rdy = !d_nearly_full && !r_nearly_full;

  // ------------------------------------------------------------ counters
  logic [COUNT_WIDTH-1:0] hit_count_reg, miss_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if (lk_pend_reg) begin
      if (lk_hit_reg) begin
        if (hit_count_reg != CNT_MAX) hit_count_reg <= hit_count_reg + 1'b1;
      end else begin
        if (miss_count_reg != CNT_MAX) miss_count_reg <= miss_count_reg + 1'b1;
      end
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

  // --------------------------------------------------------- output side
  out_state_t            out_state_reg;
  logic                  active, drop;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;

  assign {head_ctrl, head_data} = d_head;
  assign active = (out_state_reg != OUT_WAIT);
  // A dropped packet drains at full rate regardless of downstream ready.
  assign drop   = MISS_DROP && !r_hit;
  assign d_pop  = active && !d_empty && (drop || out_rdy);
  assign r_pop  = d_pop && (out_state_reg == OUT_DATA) && (head_ctrl != '0);

  always_comb begin
    out_wr   = d_pop && !drop;
    out_ctrl = head_ctrl;
    out_data = head_data;
    if (out_state_reg == OUT_HDR && head_ctrl == IOQ_CTRL)
      out_data[DATA_WIDTH-1 -: 16] = r_port;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_state_reg <= OUT_WAIT;
    end else begin
      case (out_state_reg)
        OUT_WAIT: if (!d_empty && !r_empty) out_state_reg <= OUT_HDR;
        OUT_HDR:  if (d_pop && head_ctrl == '0) out_state_reg <= OUT_DATA;
        OUT_DATA: if (d_pop && head_ctrl != '0) out_state_reg <= OUT_WAIT;
        default:  out_state_reg <= OUT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_lut_stage.sv
// -----------------------------------------------------------------------------
// tb_tcam_lut_stage
//
// Directed sequence with randomized packet contents. A reference model holds
// a copy of the table and predicts, per packet, the full list of output words
// at the moment its key word is sent. A monitor compares every out_wr word
// against that prediction queue.
// -----------------------------------------------------------------------------
module tb_tcam_lut_stage;

  localparam logic [15:0] DEFAULT_PORT = 16'h0000;
`ifdef TCAM_LUT_MISS_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        tbl_wr_en = 1'b0;
  logic [2:0]  tbl_wr_addr = '0;
  logic        tbl_wr_valid = 1'b0;
  logic [47:0] tbl_wr_value = '0;
  logic [47:0] tbl_wr_mask = '0;
  logic [15:0] tbl_wr_port = '0;
  logic [31:0] hit_count, miss_count;

  tcam_lut_stage dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_valid(tbl_wr_valid),
    .tbl_wr_value(tbl_wr_value), .tbl_wr_mask(tbl_wr_mask), .tbl_wr_port(tbl_wr_port),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [71:0] exp_q[$];
  logic        m_valid [8];
  logic [47:0] m_value [8];
  logic [47:0] m_mask  [8];
  logic [15:0] m_port  [8];
  int          exp_hits = 0, exp_misses = 0;
  bit          saw_not_rdy = 1'b0;
  bit          toggle_en = 1'b0;
  logic [7:0]  pk_ctrl [16];
  logic [63:0] pk_data [16];
  int          pk_len = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // out_rdy: steady high, or alternating every cycle while toggle_en is set.
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_rdy = toggle_en ? ~out_rdy : 1'b1;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (!reset && out_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {56'd0, out_ctrl, out_data}, 128'd0);
      end else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        $display("out ctrl=%02h data=%016h expect=%018h", out_ctrl, out_data, e);
        chk("out_word", {56'd0, out_ctrl, out_data}, {56'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // First entry, in index order, whose cared-about bits equal the key's.
  function automatic logic [16:0] model_lookup(input logic [47:0] k);
    for (int i = 0; i < 8; i++)
      if (m_valid[i] && ((k & m_mask[i]) == (m_value[i] & m_mask[i])))
        return {1'b1, m_port[i]};
    return {1'b0, DEFAULT_PORT};
  endfunction

  task automatic step();
    @(posedge clk); #1;
    in_wr = 1'b0;
    tbl_wr_en = 1'b0;
  endtask

  task automatic tbl_write(input logic [2:0] a, input logic v, input logic [47:0] val,
                           input logic [47:0] msk, input logic [15:0] p);
    step();
    tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_valid = v;
    tbl_wr_value = val; tbl_wr_mask = msk; tbl_wr_port = p;
    m_valid[a] = v; m_value[a] = val; m_mask[a] = msk; m_port[a] = p;
    $display("tbl write addr=%0d valid=%0b value=%012h mask=%012h port=%04h", a, v, val, msk, p);
  endtask

  task automatic make_pkt(input logic [7:0] hctrl, input logic [47:0] k,
                          input int n_mid, input bit with_eop);
    pk_len = 0;
    pk_ctrl[0] = hctrl;
    pk_data[0] = {(hctrl == 8'hFF) ? 16'h0000 : 16'($urandom), 16'($urandom), $urandom};
    pk_ctrl[1] = 8'h00;
    pk_data[1] = {k, 16'($urandom)};
    pk_len = 2;
    for (int i = 0; i < n_mid; i++) begin
      pk_ctrl[pk_len] = 8'h00;
      pk_data[pk_len] = {$urandom, $urandom};
      pk_len++;
    end
    if (with_eop) begin
      pk_ctrl[pk_len] = 8'(1 << $urandom_range(0, 7));
      pk_data[pk_len] = {$urandom, $urandom};
      pk_len++;
    end
  endtask

  task automatic send_pkt(input bit wr_at_key, input logic [2:0] wa, input logic wv,
                          input logic [47:0] wval, input logic [47:0] wmsk,
                          input logic [15:0] wp);
    int ki;
    logic [16:0] res;
    ki = 0;
    while (pk_ctrl[ki] != 8'h00) ki++;
    res = model_lookup(pk_data[ki][63:16]);
    if (res[16]) exp_hits++; else exp_misses++;
    $display("pkt len=%0d key=%012h hit=%0b port=%04h", pk_len, pk_data[ki][63:16], res[16], res[15:0]);
    if (!(DROP && !res[16])) begin
      for (int i = 0; i < pk_len; i++) begin
        logic [71:0] w;
        w = {pk_ctrl[i], pk_data[i]};
        if (i < ki && pk_ctrl[i] == 8'hFF) w[63:48] = res[15:0];
        exp_q.push_back(w);
      end
    end
    for (int i = 0; i < pk_len; i++) begin
      int waited;
      step();
      waited = 0;
      while (!in_rdy) begin
        saw_not_rdy = 1'b1;
        step();
        waited++;
        if (waited > 1000) begin
          chk("in_rdy_timeout", {127'd0, in_rdy}, 128'd1);
          return;
        end
      end
      in_ctrl = pk_ctrl[i];
      in_data = pk_data[i];
      in_wr   = 1'b1;
      if (wr_at_key && i == ki) begin
        tbl_wr_en = 1'b1; tbl_wr_addr = wa; tbl_wr_valid = wv;
        tbl_wr_value = wval; tbl_wr_mask = wmsk; tbl_wr_port = wp;
      end
    end
    if (wr_at_key) begin
      m_valid[wa] = wv; m_value[wa] = wval; m_mask[wa] = wmsk; m_port[wa] = wp;
    end
  endtask

  task automatic send_simple(input logic [7:0] hctrl, input logic [47:0] k, input int n_mid);
    make_pkt(hctrl, k, n_mid, 1'b1);
    send_pkt(1'b0, 3'd0, 1'b0, 48'd0, 48'd0, 16'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
    repeat (20) step();
    chk({tag, "_hits"}, hit_count, exp_hits);
    chk({tag, "_misses"}, miss_count, exp_misses);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0; m_value[i] = '0; m_mask[i] = '0; m_port[i] = '0;
    end

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_hit", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_in_rdy", in_rdy, 1);

    // Exact-match hit on entry 0
    tbl_write(3'd0, 1'b1, 48'h001122334455, 48'hFFFFFFFFFFFF, 16'h0004);
    send_simple(8'hFF, 48'h001122334455, 1);
    drain("hit0");

    // Two matching entries: lowest index wins, then entry 1 after invalidation
    tbl_write(3'd1, 1'b1, 48'h001100000000, 48'hFFFF00000000, 16'h0010);
    send_simple(8'hFF, 48'h001122334455, 1);
    drain("prio");
    tbl_write(3'd0, 1'b0, 48'h001122334455, 48'hFFFFFFFFFFFF, 16'h0004);
    send_simple(8'hFF, 48'h001122334455, 1);
    drain("inval");

    // Miss, followed by a hit packet
    send_simple(8'hFF, 48'hDEADBEEF0000, 2);
    send_simple(8'hFF, 48'h0011CAFEF00D, 0);
    drain("miss");

    // Ten back-to-back 3-word packets with out_rdy alternating
    tbl_write(3'd0, 1'b1, 48'h001122334455, 48'hFFFFFFFFFFFF, 16'h0004);
    toggle_en = 1'b1;
    saw_not_rdy = 1'b0;
    for (int p = 0; p < 10; p++) begin
      logic [47:0] k;
      logic [7:0]  hc;
      case ($urandom_range(0, 2))
        0:       k = 48'h001122334455;
        1:       k = {16'h0011, $urandom};
        default: k = {16'hA5A5, $urandom};
      endcase
      hc = ($urandom_range(0, 3) == 0) ? 8'h40 : 8'hFF;
      send_simple(hc, k, 0);
    end
    drain("b2b");
    toggle_en = 1'b0;
    chk("b2b_in_rdy_low_seen", saw_not_rdy, 1);

    // Table write in the same cycle as the key word
    make_pkt(8'hFF, 48'h001122334455, 1, 1'b1);
    send_pkt(1'b1, 3'd0, 1'b1, 48'h0A0B0C0D0E0F, 48'hFFFFFFFFFFFF, 16'h0100);
    send_simple(8'hFF, 48'h0A0B0C0D0E0F, 1);
    send_simple(8'hFF, 48'h001122334455, 1);
    drain("same_cycle_wr");

    // Reset in the middle of a packet (no EOP sent yet)
    make_pkt(8'hFF, 48'h001122334455, 1, 1'b0);
    send_pkt(1'b0, 3'd0, 1'b0, 48'd0, 48'd0, 16'd0);
    repeat (10) step();
    chk("mid_partial_out", exp_q.size(), 0);
    step();
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_wr", out_wr, 0);
    chk("mid_rst_hit", hit_count, 0);
    chk("mid_rst_miss", miss_count, 0);
    send_simple(8'hFF, 48'h001122334455, 1);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
